// File: rtl/digi_clock_rtc_pkg.sv
// Shared constants and field arithmetic for the hh:mm:ss time-of-day counter.
// Limits are plain binary numbers; enc() maps them into the active encoding.
package digi_clock_pkg;

    localparam logic [7:0] SEC_MAX     = 8'd59;
    localparam logic [7:0] MIN_MAX     = 8'd59;
    localparam logic [7:0] HOUR_MAX_24 = 8'd23;
    localparam logic [7:0] HOUR_MAX_12 = 8'd12;

    // Binary number (0..99) to the field encoding used on the ports.
    function automatic logic [7:0] enc(input logic [7:0] n, input bit bcd);
        return bcd ? (((n / 8'd10) << 4) | (n % 8'd10)) : n;
    endfunction

    // Packed-BCD increment with wrap to zero at max: returns {carry, next}.
    function automatic logic [8:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
        if (value == max)
            return {1'b1, 8'h00};
        if (value[3:0] == 4'd9)
            return {1'b0, value[7:4] + 4'd1, 4'd0};
        return {1'b0, value[7:4], value[3:0] + 4'd1};
    endfunction

    // Binary increment with wrap to zero at max: returns {carry, next}.
    function automatic logic [8:0] bin_inc(input logic [7:0] value, input logic [7:0] max);
        if (value == max)
            return {1'b1, 8'h00};
        return {1'b0, value + 8'd1};
    endfunction

    function automatic logic [8:0] field_inc(input logic [7:0] value, input logic [7:0] max,
                                             input bit bcd);
        return bcd ? bcd_inc(value, max) : bin_inc(value, max);
    endfunction

    // Range check in the active encoding; BCD values order like their binary meaning.
    function automatic logic field_ok(input logic [7:0] value, input logic [7:0] lo,
                                      input logic [7:0] hi, input bit bcd);
        logic nib_ok;
        nib_ok = !bcd || ((value[7:4] <= 4'd9) && (value[3:0] <= 4'd9));
        return nib_ok && (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/digi_clock_rtc_if.sv
// Control/load/alarm inputs and time/pulse outputs of the RTC, bundled.
interface digi_clock_rtc_if;
    logic       run;
    logic       load;
    logic [7:0] ld_hour;
    logic [7:0] ld_min;
    logic [7:0] ld_sec;
    logic       ld_pm;
    logic       alm_en;
    logic [7:0] alm_hour;
    logic [7:0] alm_min;
    logic       alm_pm;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic       pm;
    logic       sec_tick;
    logic       day_carry;
    logic       alarm_hit;
    logic       load_err;

    modport master (
        output run, load, ld_hour, ld_min, ld_sec, ld_pm, alm_en, alm_hour, alm_min, alm_pm,
        input  sec, min, hour, pm, sec_tick, day_carry, alarm_hit, load_err
    );

    modport slave (
        input  run, load, ld_hour, ld_min, ld_sec, ld_pm, alm_en, alm_hour, alm_min, alm_pm,
        output sec, min, hour, pm, sec_tick, day_carry, alarm_hit, load_err
    );
endinterface

// File: rtl/digi_clock_rtc_tick.sv
// Seconds prescaler: counts enabled cycles 0..CLK_DIV-1, tick on the wrap cycle.
module tick_prescaler #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = run_i && (cnt_q == LAST);

    // Count while running, hold while paused; a clear restarts the second.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (run_i)
            cnt_q <= tick_o ? '0 : cnt_q + CW'(1);
    end
endmodule

// File: rtl/digi_clock_rtc.sv
// Time-of-day counter: sec/min/hour carry chain, 24h or 12h+pm, binary or BCD,
// with load validation and alarm compare on tick-driven updates.
module digi_clock_rtc
    import digi_clock_pkg::*;
#(
    parameter int CLK_DIV  = 5,
    parameter int BCD      = 0,
    parameter int MODE_12H = 0
) (
    input logic            clk,
    input logic            rst,
    digi_clock_rtc_if.slave bus
);
    localparam bit         IS_BCD      = (BCD != 0);
    localparam bit         IS_12H      = (MODE_12H != 0);
    localparam logic [7:0] SEC_LIM     = enc(SEC_MAX, IS_BCD);
    localparam logic [7:0] MIN_LIM     = enc(MIN_MAX, IS_BCD);
    localparam logic [7:0] HOUR_LIM    = IS_12H ? enc(HOUR_MAX_12, IS_BCD) : enc(HOUR_MAX_24, IS_BCD);
    localparam logic [7:0] HOUR_LO     = IS_12H ? enc(8'd1, IS_BCD) : 8'd0;
    localparam logic [7:0] HOUR_RST    = IS_12H ? enc(8'd12, IS_BCD) : 8'd0;
    localparam logic [7:0] HOUR_ELEVEN = enc(8'd11, IS_BCD);

    logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic       pm_q, pm_d;
    logic       sec_tick_q, sec_tick_d, day_carry_q, day_carry_d;
    logic       alarm_hit_q, alarm_hit_d, load_err_q, load_err_d;

    logic       tick, load_ok, hour_step, pm_nx, wrap;
    logic [8:0] sec_inc, min_inc, hour_inc;
    logic [7:0] hour_nx;

    assign load_ok = bus.load
                  && field_ok(bus.ld_sec,  8'd0,    SEC_LIM,  IS_BCD)
                  && field_ok(bus.ld_min,  8'd0,    MIN_LIM,  IS_BCD)
                  && field_ok(bus.ld_hour, HOUR_LO, HOUR_LIM, IS_BCD);

    // A load (valid or not) freezes the prescaler that cycle so a coincident tick is lost.
    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .run_i  (bus.run && !bus.load),
        .clr_i  (load_ok),
        .tick_o (tick)
    );

    // Next time and pulses: load wins over tick; alarm compares the post-tick time.
    always_comb begin
        sec_inc   = field_inc(sec_q,  SEC_LIM,  IS_BCD);
        min_inc   = field_inc(min_q,  MIN_LIM,  IS_BCD);
        hour_inc  = field_inc(hour_q, HOUR_LIM, IS_BCD);
        hour_step = sec_inc[8] && min_inc[8];
        if (IS_12H) begin
            hour_nx = (hour_q == HOUR_LIM) ? HOUR_LO : hour_inc[7:0];
            pm_nx   = (hour_q == HOUR_ELEVEN) ? !pm_q : pm_q;
            wrap    = (hour_q == HOUR_ELEVEN) && pm_q;
        end else begin
            hour_nx = hour_inc[7:0];
            pm_nx   = 1'b0;
            wrap    = hour_inc[8];
        end

        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        pm_d        = pm_q;
        sec_tick_d  = 1'b0;
        day_carry_d = 1'b0;
        alarm_hit_d = 1'b0;
        load_err_d  = 1'b0;

        if (bus.load) begin
            if (load_ok) begin
                sec_d  = bus.ld_sec;
                min_d  = bus.ld_min;
                hour_d = bus.ld_hour;
                pm_d   = IS_12H ? bus.ld_pm : 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            sec_d      = sec_inc[7:0];
            sec_tick_d = 1'b1;
            if (sec_inc[8])
                min_d = min_inc[7:0];
            if (hour_step) begin
                hour_d      = hour_nx;
                pm_d        = pm_nx;
                day_carry_d = wrap;
            end
            alarm_hit_d = bus.alm_en && (hour_d == bus.alm_hour) && (min_d == bus.alm_min)
                       && (sec_d == 8'd0) && (!IS_12H || (pm_d == bus.alm_pm));
        end
    end

    // Time registers and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sec_q       <= 8'd0;
            min_q       <= 8'd0;
            hour_q      <= HOUR_RST;
            pm_q        <= 1'b0;
            sec_tick_q  <= 1'b0;
            day_carry_q <= 1'b0;
            alarm_hit_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            pm_q        <= pm_d;
            sec_tick_q  <= sec_tick_d;
            day_carry_q <= day_carry_d;
            alarm_hit_q <= alarm_hit_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = hour_q;
    assign bus.pm        = pm_q;
    assign bus.sec_tick  = sec_tick_q;
    assign bus.day_carry = day_carry_q;
    assign bus.alarm_hit = alarm_hit_q;
    assign bus.load_err  = load_err_q;
endmodule
